vblank_update_scheduler: RTL and testbench

//  Sequences per-frame game-logic updates (physics, collision, score, sprite select) during

---
 rtl/vblank_update_scheduler_if.sv | 10 +
 rtl/vblank_update_scheduler.sv | 119 +++++++++++
 tb/tb_vblank_update_scheduler.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vblank_update_scheduler_if.sv
// Request/acknowledge bundle between the vblank scheduler (master) and its update engines (slave).
interface vblank_update_scheduler_if #(
  parameter int unsigned N_STAGES = 4
);
  logic [N_STAGES-1:0] req;
  logic [N_STAGES-1:0] ack;

  modport master (output req, input ack);
  modport slave  (input req, output ack);
endinterface

// File: rtl/vblank_update_scheduler.sv
// Sequences per-frame update engines through a one-hot req/ack walk on each vblank entry.
// Optional per-stage watchdog is built only when WATCHDOG_EN is defined.
module vblank_update_scheduler #(
  parameter int unsigned N_STAGES  = 4,
  parameter int unsigned FRAME_DIV = 1,
  parameter int unsigned TIMEOUT   = 4095
) (
  input  logic                             pixel_clock,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             vblank,
  input  logic                             clr_overrun,
  vblank_update_scheduler_if.master        upd,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             overrun,
  output logic                             timed_out,
  output logic [15:0]                      frame_cnt
);
  localparam int unsigned SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [N_STAGES-1:0] req_q, req_d;
  logic                vblank_d;
  logic [3:0]          div_cnt;
  logic                vblank_rise, vblank_fall, start_ok;
  logic                stage_ack, stage_exp, stage_adv, last_stage, ovr_set;

  assign vblank_rise = vblank & ~vblank_d;
  assign vblank_fall = ~vblank & vblank_d;
  assign start_ok    = vblank_rise & enable & (div_cnt == '0);
  assign last_stage  = (stage_q == SW'(N_STAGES - 1));
  assign stage_ack   = upd.ack[stage_q];
  assign stage_adv   = (state_q == RUN) & (stage_ack | stage_exp);
  assign ovr_set     = (vblank_fall & (state_q == RUN)) | (start_ok & (state_q != IDLE));
  assign upd.req     = req_q;

`ifdef WATCHDOG_EN
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [WW-1:0] wd_cnt;
  logic          timed_out_q;

  assign stage_exp = (state_q == RUN) & (wd_cnt == WW'(TIMEOUT - 1));
  assign timed_out = timed_out_q;

  // Counter restarts on every stage change, so each stage gets a full TIMEOUT budget.
  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if ((state_q != RUN) || stage_adv) wd_cnt <= '0;
      else                               wd_cnt <= wd_cnt + 1'b1;
      if (stage_exp & ~stage_ack) timed_out_q <= 1'b1;
      else if (clr_overrun)       timed_out_q <= 1'b0;
    end
  end
`else
  assign stage_exp = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    req_d   = req_q;
    case (state_q)
      IDLE: if (start_ok) begin
        state_d = RUN;
        stage_d = '0;
        req_d   = N_STAGES'(1);
      end
      RUN: if (stage_adv) begin
        if (last_stage) begin
          req_d   = '0;
          state_d = DONE;
        end else begin
          stage_d = stage_q + 1'b1;
          req_d   = req_q << 1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
  end

  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      stage_q   <= '0;
      req_q     <= '0;
      vblank_d  <= 1'b0;
      div_cnt   <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      req_q    <= req_d;
      vblank_d <= vblank;
      if (vblank_rise & enable)
        div_cnt <= (div_cnt == 4'(FRAME_DIV - 1)) ? '0 : div_cnt + 1'b1;
      if (state_q == DONE) frame_cnt <= frame_cnt + 1'b1;
      if (ovr_set)          overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Scoreboard bench for vblank_update_scheduler; watchdog checks follow WATCHDOG_EN.
`timescale 1ns/1ps
module tb_vblank_update_scheduler;
  logic        pixel_clock = 1'b0;
  logic        rst, enable, vblank, vblank_b, clr_overrun;
  logic        busy, frame_done, overrun, timed_out;
  logic        busy_b, frame_done_b, overrun_b, timed_out_b;
  logic [15:0] frame_cnt, frame_cnt_b;

  vblank_update_scheduler_if #(.N_STAGES(4)) bus_a ();
  vblank_update_scheduler_if #(.N_STAGES(4)) bus_b ();

  vblank_update_scheduler #(.N_STAGES(4), .FRAME_DIV(1), .TIMEOUT(16)) dut_a (
    .pixel_clock(pixel_clock), .rst(rst), .enable(enable), .vblank(vblank),
    .clr_overrun(clr_overrun), .upd(bus_a.master), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .timed_out(timed_out), .frame_cnt(frame_cnt));

  vblank_update_scheduler #(.N_STAGES(4), .FRAME_DIV(3), .TIMEOUT(16)) dut_b (
    .pixel_clock(pixel_clock), .rst(rst), .enable(enable), .vblank(vblank_b),
    .clr_overrun(clr_overrun), .upd(bus_b.master), .busy(busy_b), .frame_done(frame_done_b),
    .overrun(overrun_b), .timed_out(timed_out_b), .frame_cnt(frame_cnt_b));

  always #20 pixel_clock = ~pixel_clock;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_req_q[$];
  logic [15:0] exp_done_q[$];
  logic [15:0] exp_cnt_b_q[$];
  logic [3:0]  prev_req = '0;
  int          age = 0;
  int          ack_delay = 3;
  logic        hold_en = 1'b0;
  logic [3:0]  hold_mask = '0;
  bit          done_seen = 0;
  logic [15:0] model_cnt = '0;
  logic [15:0] model_cnt_b = '0;

  task automatic push_sequence();
    exp_req_q.push_back(4'b0001);
    exp_req_q.push_back(4'b0010);
    exp_req_q.push_back(4'b0100);
    exp_req_q.push_back(4'b1000);
    exp_done_q.push_back(model_cnt);
    model_cnt = model_cnt + 1'b1;
  endtask

  // Advance n cycles: score req grants and frame_done, then drive the engine acks.
  task automatic watch(input int n);
    logic [3:0]  e;
    logic [15:0] ec;
    for (int k = 0; k < n; k++) begin
      @(negedge pixel_clock);
      if (bus_a.req !== prev_req) begin
        if (bus_a.req !== 4'b0000) begin
          checks++;
          if (exp_req_q.size() == 0) begin
            errors++;
            $display("FAIL req_order: got req=%b, required no request", bus_a.req);
          end else begin
            e = exp_req_q.pop_front();
            if (bus_a.req !== e) begin
              errors++;
              $display("FAIL req_order: got req=%b, required %b", bus_a.req, e);
            end
          end
        end
        age = 0;
      end else begin
        age++;
      end
      prev_req = bus_a.req;
      if (frame_done === 1'b1) begin
        done_seen = 1;
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL frame_done: got unexpected pulse, required none");
        end else begin
          ec = exp_done_q.pop_front();
          if (frame_cnt !== ec) begin
            errors++;
            $display("FAIL frame_done_cnt: got %0d, required %0d", frame_cnt, ec);
          end
        end
      end
      if (!rst && bus_a.req !== 4'b0000 && age >= ack_delay && !(hold_en && bus_a.req === hold_mask))
        bus_a.ack = bus_a.req;
      else
        bus_a.ack = '0;
    end
  endtask

  task automatic wait_done(input int max);
    done_seen = 0;
    for (int i = 0; i < max && !done_seen; i++) watch(1);
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL wait_done: got no frame_done within %0d cycles, required a pulse", max);
    end
  endtask

  task automatic wait_req(input logic [3:0] mask, input int max);
    for (int i = 0; i < max && bus_a.req !== mask; i++) watch(1);
    checks++;
    if (bus_a.req !== mask) begin
      errors++;
      $display("FAIL wait_req: got req=%b, required %b", bus_a.req, mask);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge pixel_clock);
    checks++;
    if ({bus_a.req, busy, frame_done, overrun, timed_out, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_a: got req=%b busy=%b done=%b ovr=%b to=%b cnt=%0d, required all 0",
               bus_a.req, busy, frame_done, overrun, timed_out, frame_cnt);
    end
    checks++;
    if ({bus_b.req, busy_b, frame_done_b, overrun_b, timed_out_b, frame_cnt_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: got req=%b busy=%b cnt=%0d, required all 0", bus_b.req, busy_b, frame_cnt_b);
    end
    rst = 1'b0;
    watch(2);
  endtask

  task automatic test_basic();
    enable = 1'b1;
    ack_delay = 3;
    push_sequence();
    vblank = 1'b1;
    watch(1);
    checks++;
    if (bus_a.req !== 4'b0001) begin
      errors++;
      $display("FAIL start_latency: got req=%b, required 0001", bus_a.req);
    end
    wait_done(60);
    watch(1);
    checks++;
    if (frame_cnt !== model_cnt || overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: got cnt=%0d ovr=%b busy=%b, required cnt=%0d ovr=0 busy=0",
               frame_cnt, overrun, busy, model_cnt);
    end
    vblank = 1'b0;
    watch(2);
  endtask

  task automatic test_back_to_back();
    int cycles = 0;
    int nreq = 0;
    ack_delay = 0;
    push_sequence();
    vblank = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      watch(1);
      cycles++;
      if (bus_a.req !== 4'b0000) nreq++;
    end
    checks++;
    if (cycles != 5 || nreq != 4) begin
      errors++;
      $display("FAIL back_to_back: got %0d cycles to done with %0d req cycles, required 5 and 4",
               cycles, nreq);
    end
    watch(1);
    vblank = 1'b0;
    watch(2);
  endtask

  task automatic test_enable_drop();
    ack_delay = 2;
    push_sequence();
    vblank = 1'b1;
    watch(1);
    enable = 1'b0;
    wait_done(60);
    watch(1);
    checks++;
    if (frame_cnt !== model_cnt) begin
      errors++;
      $display("FAIL enable_mid_run: got cnt=%0d, required %0d", frame_cnt, model_cnt);
    end
    vblank = 1'b0;
    watch(2);
    vblank = 1'b1;
    watch(6);
    checks++;
    if (busy !== 1'b0 || frame_cnt !== model_cnt) begin
      errors++;
      $display("FAIL enable_low_start: got busy=%b cnt=%0d, required busy=0 cnt=%0d",
               busy, frame_cnt, model_cnt);
    end
    vblank = 1'b0;
    enable = 1'b1;
    watch(2);
  endtask

  task automatic test_frame_div();
    logic [15:0] ec;
    for (int i = 0; i < 6; i++) begin
      vblank_b = 1'b1;
      watch(1);
      checks++;
      if (busy_b !== ((i % 3) == 0)) begin
        errors++;
        $display("FAIL frame_div_start rise %0d: got busy=%b, required %b", i + 1, busy_b, (i % 3) == 0);
      end
      if ((i % 3) == 0) model_cnt_b = model_cnt_b + 1'b1;
      exp_cnt_b_q.push_back(model_cnt_b);
      watch(7);
      vblank_b = 1'b0;
      ec = exp_cnt_b_q.pop_front();
      checks++;
      if (frame_cnt_b !== ec) begin
        errors++;
        $display("FAIL frame_div_cnt rise %0d: got %0d, required %0d", i + 1, frame_cnt_b, ec);
      end
      watch(2);
    end
    checks++;
    if (overrun_b !== 1'b0) begin
      errors++;
      $display("FAIL frame_div_overrun: got %b, required 0", overrun_b);
    end
  endtask

  task automatic test_overrun();
    ack_delay = 1;
    hold_mask = 4'b0100;
    hold_en = 1'b1;
    push_sequence();
    vblank = 1'b1;
    wait_req(4'b0100, 40);
    watch(3);
    vblank = 1'b0;
    watch(1);
    checks++;
    if (overrun !== 1'b1 || bus_a.req !== 4'b0100) begin
      errors++;
      $display("FAIL overrun_fall: got ovr=%b req=%b, required ovr=1 req=0100", overrun, bus_a.req);
    end
    clr_overrun = 1'b1;
    watch(1);
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b, required 0", overrun);
    end
    vblank = 1'b1;
    clr_overrun = 1'b1;
    watch(1);
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b1 || bus_a.req !== 4'b0100) begin
      errors++;
      $display("FAIL overrun_drop_set_wins: got ovr=%b req=%b, required ovr=1 req=0100", overrun, bus_a.req);
    end
    hold_en = 1'b0;
    wait_done(40);
    watch(1);
    checks++;
    if (frame_cnt !== model_cnt || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_complete: got cnt=%0d ovr=%b, required cnt=%0d ovr=1", frame_cnt, overrun, model_cnt);
    end
    watch(8);
    checks++;
    if (busy !== 1'b0 || frame_cnt !== model_cnt) begin
      errors++;
      $display("FAIL dropped_start: got busy=%b cnt=%0d, required busy=0 cnt=%0d", busy, frame_cnt, model_cnt);
    end
    vblank = 1'b0;
    clr_overrun = 1'b1;
    watch(1);
    clr_overrun = 1'b0;
    watch(1);
  endtask

  task automatic test_reset_mid();
    ack_delay = 1;
    hold_mask = 4'b0100;
    hold_en = 1'b1;
    push_sequence();
    vblank = 1'b1;
    wait_req(4'b0100, 40);
    #5;
    rst = 1'b1;
    #1;
    checks++;
    if (bus_a.req !== 4'b0000 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got req=%b busy=%b cnt=%0d, required req=0000 busy=0 cnt=0",
               bus_a.req, busy, frame_cnt);
    end
    model_cnt = '0;
    model_cnt_b = '0;
    exp_req_q.delete();
    exp_done_q.delete();
    prev_req = '0;
    age = 0;
    hold_en = 1'b0;
    vblank = 1'b0;
    bus_a.ack = '0;
    @(negedge pixel_clock);
    rst = 1'b0;
    watch(2);
  endtask

  task automatic test_watchdog();
    ack_delay = 1;
    hold_mask = 4'b0010;
    hold_en = 1'b1;
    push_sequence();
    vblank = 1'b1;
    wait_req(4'b0010, 20);
`ifdef WATCHDOG_EN
    begin
      int  n = 1;
      bit  moved = 0;
      for (int i = 0; i < 100 && !moved; i++) begin
        watch(1);
        if (bus_a.req === 4'b0010) n++;
        else moved = 1;
      end
      checks++;
      if (n != 16 || bus_a.req !== 4'b0100 || timed_out !== 1'b1) begin
        errors++;
        $display("FAIL watchdog_expire: got %0d cycles req=%b to=%b, required 16 cycles req=0100 to=1",
                 n, bus_a.req, timed_out);
      end
      hold_en = 1'b0;
      wait_done(40);
      clr_overrun = 1'b1;
      watch(1);
      clr_overrun = 1'b0;
      checks++;
      if (timed_out !== 1'b0) begin
        errors++;
        $display("FAIL watchdog_clear: got to=%b, required 0", timed_out);
      end
    end
`else
    watch(40);
    checks++;
    if (bus_a.req !== 4'b0010 || timed_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_no_watchdog: got req=%b to=%b busy=%b, required req=0010 to=0 busy=1",
               bus_a.req, timed_out, busy);
    end
    hold_en = 1'b0;
    wait_done(20);
`endif
    watch(1);
    checks++;
    if (frame_cnt !== model_cnt) begin
      errors++;
      $display("FAIL watchdog_cnt: got %0d, required %0d", frame_cnt, model_cnt);
    end
    vblank = 1'b0;
    watch(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    vblank = 1'b0;
    vblank_b = 1'b0;
    clr_overrun = 1'b0;
    bus_a.ack = '0;
    bus_b.ack = '1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_enable_drop();
    test_frame_div();
    test_overrun();
    test_reset_mid();
    test_watchdog();
    checks++;
    if (exp_req_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d req and %0d done entries left, required 0",
               exp_req_q.size(), exp_done_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
